// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - iterative AES-128 key schedule, one round key per handshake
// Keeps only a 4-word window of the key stream and derives one new word per GEN cycle.
module aes_key_expand_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         abort,
  input  logic         keyValid,
  output logic         keyReady,
  input  logic [127:0] cipherKey,
  output logic         rkValid,
  input  logic         rkReady,
  output logic [127:0] roundKey,
  output logic [3:0]   rkIndex,
  output logic         rkLast
);

  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_key_expand_seq: only NUM_ROUNDS = 10 is supported");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_GEN} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_w0, r_w1, r_w2, r_w3;
  logic [3:0]  r_round;
  logic [7:0]  r_rcon;
  logic [1:0]  r_word_cnt;
  logic [31:0] w_rot;
  logic [31:0] w_sub;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  assign w_rot = {r_w3[23:0], r_w3[31:24]};
  assign w_sub = sub_word(w_rot);

  always_ff @(posedge clk) begin
    if (!resetN) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (keyValid) w_next = ST_EMIT;
        ST_EMIT: if (rkReady)  w_next = (r_round == LAST_ROUND) ? ST_IDLE : ST_GEN;
        ST_GEN:  if (r_word_cnt == 2'd3) w_next = ST_EMIT;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    keyReady = (r_state == ST_IDLE);
    rkValid  = (r_state == ST_EMIT);
    rkLast   = (r_state == ST_EMIT) && (r_round == LAST_ROUND);
  end

  assign roundKey = {r_w0, r_w1, r_w2, r_w3};
  assign rkIndex  = r_round;

  // Abort only redirects the FSM; the key window is left as-is until the next load.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_w0       <= '0;
      r_w1       <= '0;
      r_w2       <= '0;
      r_w3       <= '0;
      r_round    <= '0;
      r_rcon     <= 8'h01;
      r_word_cnt <= '0;
    end else if (!abort) begin
      case (r_state)
        ST_IDLE: if (keyValid) begin
          r_w0    <= cipherKey[127:96];
          r_w1    <= cipherKey[95:64];
          r_w2    <= cipherKey[63:32];
          r_w3    <= cipherKey[31:0];
          r_round <= '0;
          r_rcon  <= 8'h01;
        end
        ST_EMIT: if (rkReady) r_word_cnt <= '0;
        ST_GEN: begin
          r_word_cnt <= r_word_cnt + 2'd1;
          case (r_word_cnt)
            2'd0: r_w0 <= r_w0 ^ w_sub ^ {r_rcon, 24'h0};
            2'd1: r_w1 <= r_w1 ^ r_w0;
            2'd2: r_w2 <= r_w2 ^ r_w1;
            default: begin
              r_w3    <= r_w3 ^ r_w2;
              r_round <= r_round + 4'd1;
              r_rcon  <= xtime(r_rcon);
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - self-checking bench for aes_key_expand_seq
// Reference key schedule is computed from GF(2^8) arithmetic and the word-recurrence definition.
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         abort = 1'b0;
  logic         keyValid = 1'b0;
  logic         keyReady;
  logic [127:0] cipherKey = '0;
  logic         rkValid;
  logic         rkReady = 1'b0;
  logic [127:0] roundKey;
  logic [3:0]   rkIndex;
  logic         rkLast;

  aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .resetN(resetN), .abort(abort), .keyValid(keyValid), .keyReady(keyReady),
    .cipherKey(cipherKey), .rkValid(rkValid), .rkReady(rkReady), .roundKey(roundKey),
    .rkIndex(rkIndex), .rkLast(rkLast)
  );

  always #5 clk = ~clk;

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];
  logic [127:0] obs_rk [11];
  int           n_hs;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_key(input logic [127:0] key);
    chk("key_ready_before_load", keyReady, 1);
    keyValid  = 1'b1;
    cipherKey = key;
    step();
    keyValid  = 1'b0;
  endtask

  // Loads a key and follows all 11 round keys; optional consumer stalls and stray key offers.
  task automatic run_seq(input logic [127:0] key, input bit stall, input bit stray_keys);
    int           c = 1;
    int           idx = 0;
    int           stall_left = 0;
    bit           new_round = 1'b1;
    bit           was_stalled = 1'b0;
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_idx = '0;
    compute_model(key);
    load_key(key);
    n_hs = 0;
    while (idx < 11 && c < 2000) begin
      if (stray_keys) begin
        keyValid  = 1'b1;
        cipherKey = {$urandom, $urandom, $urandom, $urandom};
      end
      if (rkLast && !rkValid) chk("rklast_without_rkvalid", rkLast, 0);
      if (rkValid) begin
        if (was_stalled) begin
          chk("stall_stable_key", roundKey, prev_key);
          chk("stall_stable_idx", rkIndex, prev_idx);
        end
        chk($sformatf("round_key_%0d", idx), roundKey, exp_rk[idx]);
        chk($sformatf("rk_index_%0d", idx), rkIndex, idx);
        chk($sformatf("rk_last_%0d", idx), rkLast, idx == 10);
        if (new_round) begin
          if (!stall) chk($sformatf("rk_cycle_%0d", idx), c, 1 + 5 * idx);
          stall_left = stall ? $urandom_range(0, 7) : 0;
          new_round  = 1'b0;
        end
        rkReady = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        obs_rk[idx] = roundKey;
        prev_key    = roundKey;
        prev_idx    = rkIndex;
        was_stalled = !rkReady;
        if (rkReady) begin
          idx++;
          n_hs++;
          new_round = 1'b1;
        end
      end else begin
        rkReady     = 1'($urandom_range(0, 1));
        was_stalled = 1'b0;
      end
      step();
      c++;
    end
    keyValid = 1'b0;
    chk("sequence_completed", idx, 11);
    chk("handshake_count", n_hs, 11);
    if (!stall) chk("end_cycle", c, 52);
    chk("key_ready_after_last", keyReady, 1);
    chk("rk_valid_after_last", rkValid, 0);
    rkReady = 1'b0;
  endtask

  initial begin
    build_sbox();
    chk("sbox_00", sb[0], 8'h63);
    chk("sbox_53", sb[8'h53], 8'hed);

    // Reset state
    resetN = 1'b0;
    step();
    step();
    chk("reset_key_ready", keyReady, 1);
    chk("reset_rk_valid", rkValid, 0);
    chk("reset_rk_last", rkLast, 0);
    chk("reset_round_key", roundKey, 0);
    chk("reset_rk_index", rkIndex, 0);
    resetN = 1'b1;
    step();

    // FIPS-197 key, consumer always ready
    run_seq(FIPS_KEY, 1'b0, 1'b0);
    chk("fips_round0", obs_rk[0], FIPS_KEY);
    chk("fips_round1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_round10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // All-zero key
    run_seq(ZERO_KEY, 1'b0, 1'b0);
    chk("zero_round1", obs_rk[1], 128'h62636363626363636263636362636363);
    chk("zero_round10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // FIPS key with random back-pressure
    run_seq(FIPS_KEY, 1'b1, 1'b0);
    chk("stall_fips_round10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Abort in the middle of round 4 generation
    load_key(FIPS_KEY);
    rkReady = 1'b1;
    repeat (22) step();
    chk("abort_pre_in_gen", rkValid, 0);
    chk("abort_pre_index", rkIndex, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_key_ready", keyReady, 1);
    chk("abort_rk_valid", rkValid, 0);
    chk("abort_rk_last", rkLast, 0);
    repeat (3) begin
      step();
      chk("abort_no_stale_valid", rkValid, 0);
    end
    abort     = 1'b1;
    keyValid  = 1'b1;
    cipherKey = ZERO_KEY;
    step();
    abort    = 1'b0;
    keyValid = 1'b0;
    chk("abort_beats_load_ready", keyReady, 1);
    chk("abort_beats_load_valid", rkValid, 0);
    rkReady = 1'b0;
    run_seq(ZERO_KEY, 1'b0, 1'b0);

    // Reset during round 7 emission
    load_key(FIPS_KEY);
    rkReady = 1'b1;
    repeat (35) step();
    chk("pre_reset_valid", rkValid, 1);
    chk("pre_reset_index", rkIndex, 7);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    chk("midreset_key_ready", keyReady, 1);
    chk("midreset_rk_valid", rkValid, 0);
    chk("midreset_rk_last", rkLast, 0);
    chk("midreset_round_key", roundKey, 0);
    chk("midreset_rk_index", rkIndex, 0);
    rkReady = 1'b0;
    run_seq(FIPS_KEY, 1'b0, 1'b0);

    // Stray keys offered while busy
    run_seq(ZERO_KEY, 1'b0, 1'b1);

    // Random keys with random back-pressure
    repeat (3) run_seq({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
